// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the RV32I memory-access stage:
//   - EXE_* load/store type codes carried on load_store_type
//   - access_bytes(): number of bytes moved over the byte-wide RAM port
// No ports (package).
// -----------------------------------------------------------------------------
package mem_stage_pkg;

   localparam logic [3:0] EXE_LB  = 4'd0;
   localparam logic [3:0] EXE_LH  = 4'd1;
   localparam logic [3:0] EXE_LW  = 4'd2;
   localparam logic [3:0] EXE_LBU = 4'd3;
   localparam logic [3:0] EXE_LHU = 4'd4;
   localparam logic [3:0] EXE_SB  = 4'd5;
   localparam logic [3:0] EXE_SH  = 4'd6;
   localparam logic [3:0] EXE_SW  = 4'd7;

   // Bytes per access; anything that is not a byte or halfword moves a word.
   function automatic logic [2:0] access_bytes(input logic [3:0] ls_type);
      case (ls_type)
         EXE_LB, EXE_LBU, EXE_SB: access_bytes = 3'd1;
         EXE_LH, EXE_LHU, EXE_SH: access_bytes = 3'd2;
         default:                 access_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ext_unit.sv
// -----------------------------------------------------------------------------
// mem_ext_unit
// Combinational byte assembly and load extension. The four captured RAM bytes
// (little-endian, byte 0 = lowest address) are packed into a word and then
// sign- or zero-extended according to the load type.
// Ports:
//   bytes_in         in  8 x 4  captured load bytes
//   load_store_type  in  4      EXE_* code
//   data             out 32     extended load result
// -----------------------------------------------------------------------------
module mem_ext_unit
   import mem_stage_pkg::*;
(
   input  logic [7:0]  bytes_in [4],
   input  logic [3:0]  load_store_type,
   output logic [31:0] data
);

   logic [31:0] raw;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_pack
         assign raw[8*gi +: 8] = bytes_in[gi];
      end
   endgenerate

   always_comb begin
      data = raw;
      case (load_store_type)
         EXE_LB:  data = {{24{raw[7]}}, raw[7:0]};
         EXE_LBU: data = {24'h0, raw[7:0]};
         EXE_LH:  data = {{16{raw[15]}}, raw[15:0]};
         EXE_LHU: data = {16'h0, raw[15:0]};
         default: data = raw;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory-access stage of the 5-stage RV32I pipeline (between EX/MEM and MEM/WB).
// Loads and stores are serialised byte by byte over a shared byte-wide RAM port;
// the pipeline is stalled until the access completes. Non-memory results pass
// straight through to WB in the same cycle.
//
// Optional feature: define MEM_STAGE_FW_EN to drive the ID forwarding outputs
// (mem_fw/mem_fw_addr/mem_fw_data) from the WB-bound results; otherwise they
// are tied to zero.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   rd_data_i/rd_addr_i/rd_enable_i   EX result / dest reg / write enable
//   load_enable, store_enable, mem_addr_i, load_store_type   memory request
//   bus_req / bus_gnt        shared RAM port arbitration
//   mem_a, mem_dout, mem_din, mem_wr   byte RAM port (read data 1 cycle late)
//   stall_req                freeze PC..EX/MEM while an access is running
//   rd_data_o/rd_addr_o/rd_enable_o   to MEM/WB
//   mem_fw, mem_fw_addr, mem_fw_data  forwarding to ID
// -----------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rd_data_i,
   input  logic [4:0]        rd_addr_i,
   input  logic              rd_enable_i,
   input  logic              load_enable,
   input  logic              store_enable,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [3:0]        load_store_type,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [ADDR_W-1:0] mem_a,
   output logic [7:0]        mem_dout,
   input  logic [7:0]        mem_din,
   output logic              mem_wr,
   output logic              stall_req,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [4:0]        rd_addr_o,
   output logic              rd_enable_o,
   output logic              mem_fw,
   output logic [4:0]        mem_fw_addr,
   output logic [DATA_W-1:0] mem_fw_data
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   logic [1:0] state_reg, state_next;
   logic [2:0] cnt_reg, cnt_next;
   logic [7:0] buf_reg [4];

   logic       mem_op;
   logic       is_store;
   logic [2:0] n_bytes;
   logic [2:0] addr_off;
   logic       capture;
   logic [3:0] byte_we;
   logic [7:0] store_byte;
   logic [31:0] ext_data;

   // A simultaneous load+store request is handled as a store.
   assign mem_op   = load_enable | store_enable;
   assign is_store = store_enable;
   assign n_bytes  = access_bytes(load_store_type);

   // Loads spend one extra cycle at cnt==N to collect the last (late) byte;
   // the address is held on the final byte during that cycle.
   assign addr_off = (!is_store && (cnt_reg == n_bytes)) ? (cnt_reg - 3'd1) : cnt_reg;

   // Read data lags its address by one cycle, so the byte seen at cnt
   // belongs to address offset cnt-1.
   assign capture = (state_reg == ST_ACCESS) && !is_store && (cnt_reg != 3'd0);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_byte_we
         assign byte_we[gi] = capture && (cnt_reg == 3'(gi + 1));
      end
   endgenerate

   always_comb begin
      store_byte = 8'h00;
      case (cnt_reg[1:0])
         2'd0: store_byte = rd_data_i[7:0];
         2'd1: store_byte = rd_data_i[15:8];
         2'd2: store_byte = rd_data_i[23:16];
         2'd3: store_byte = rd_data_i[31:24];
         default: store_byte = 8'h00;
      endcase
   end

   mem_ext_unit u_ext (
      .bytes_in        (buf_reg),
      .load_store_type (load_store_type),
      .data            (ext_data)
   );

   // State register, byte counter and load buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 3'd0;
         for (int i = 0; i < 4; i++) begin
            buf_reg[i] <= 8'h00;
         end
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         for (int i = 0; i < 4; i++) begin
            if (byte_we[i]) begin
               buf_reg[i] <= mem_din;
            end
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (mem_op && bus_gnt) begin
               state_next = ST_ACCESS;
               cnt_next   = 3'd0;
            end
         end
         ST_ACCESS: begin
            cnt_next = cnt_reg + 3'd1;
            if (is_store && (cnt_reg == n_bytes - 3'd1)) begin
               state_next = ST_DONE;
               cnt_next   = 3'd0;
            end else if (!is_store && (cnt_reg == n_bytes)) begin
               state_next = ST_DONE;
               cnt_next   = 3'd0;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            cnt_next   = 3'd0;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = 3'd0;
         end
      endcase
   end

   // Output logic. While reset is held every output is forced to zero,
   // including the otherwise combinational pass-through paths.
   always_comb begin
      bus_req     = 1'b0;
      stall_req   = 1'b0;
      mem_a       = '0;
      mem_dout    = 8'h00;
      mem_wr      = 1'b0;
      rd_data_o   = '0;
      rd_addr_o   = 5'd0;
      rd_enable_o = 1'b0;
      if (rst) begin
         case (state_reg)
            ST_IDLE: begin
               rd_data_o = rd_data_i;
               rd_addr_o = rd_addr_i;
               if (mem_op) begin
                  bus_req   = 1'b1;
                  stall_req = 1'b1;
               end else begin
                  rd_enable_o = rd_enable_i;
               end
            end
            ST_ACCESS: begin
               bus_req   = 1'b1;
               stall_req = 1'b1;
               rd_data_o = rd_data_i;
               rd_addr_o = rd_addr_i;
               mem_a     = mem_addr_i + ADDR_W'(addr_off);
               if (is_store) begin
                  mem_wr   = 1'b1;
                  mem_dout = store_byte;
               end
            end
            ST_DONE: begin
               rd_addr_o = rd_addr_i;
               if (is_store) begin
                  rd_data_o = rd_data_i;
               end else begin
                  rd_data_o   = ext_data;
                  rd_enable_o = rd_enable_i;
               end
            end
            default: begin
               rd_data_o = '0;
            end
         endcase
      end
   end

`ifdef MEM_STAGE_FW_EN
   assign mem_fw      = rd_enable_o;
   assign mem_fw_addr = rd_addr_o;
   assign mem_fw_data = rd_data_o;
`else
   assign mem_fw      = 1'b0;
   assign mem_fw_addr = 5'd0;
   assign mem_fw_data = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] rd_data_i;
   logic [4:0]  rd_addr_i;
   logic        rd_enable_i;
   logic        load_enable;
   logic        store_enable;
   logic [31:0] mem_addr_i;
   logic [3:0]  load_store_type;
   logic        bus_req;
   logic        bus_gnt;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        mem_wr;
   logic        stall_req;
   logic [31:0] rd_data_o;
   logic [4:0]  rd_addr_o;
   logic        rd_enable_o;
   logic        mem_fw;
   logic [4:0]  mem_fw_addr;
   logic [31:0] mem_fw_data;

   int checks = 0;
   int failures = 0;

   // Byte RAM model: registered read, write on mem_wr, bench preload port.
   logic [7:0] ram [1024];
   logic       pre_we = 1'b0;
   logic [9:0] pre_addr = 10'd0;
   logic [7:0] pre_data = 8'h00;

   mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
      .load_enable(load_enable), .store_enable(store_enable),
      .mem_addr_i(mem_addr_i), .load_store_type(load_store_type),
      .bus_req(bus_req), .bus_gnt(bus_gnt),
      .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din), .mem_wr(mem_wr),
      .stall_req(stall_req),
      .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
      .mem_fw(mem_fw), .mem_fw_addr(mem_fw_addr), .mem_fw_data(mem_fw_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_din <= ram[mem_a[9:0]];
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
      else if (pre_we) ram[pre_addr] <= pre_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      tick();
      pre_we   = 1'b0;
   endtask

   task automatic set_op(input logic ld, input logic st, input logic [3:0] typ,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rde);
      load_enable     = ld;
      store_enable    = st;
      load_store_type = typ;
      mem_addr_i      = addr;
      rd_data_i       = data;
      rd_addr_i       = rd;
      rd_enable_i     = rde;
   endtask

   // Runs a granted load to completion, checks latency and result, returns to IDLE.
   task automatic do_load(input string tag, input logic [3:0] typ, input logic [31:0] addr,
                          input logic [31:0] exp, input int nb);
      int n;
      set_op(1'b1, 1'b0, typ, addr, 32'hDEAD_BEEF, 5'd9, 1'b1);
      bus_gnt = 1'b1;
      #1;
      n = 0;
      while (stall_req && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_cycles"}, 32'(n), 32'(nb + 2));
      chk({tag, "_stall"}, 32'(stall_req), 32'd0);
      chk({tag, "_data"}, rd_data_o, exp);
      chk({tag, "_rde"}, 32'(rd_enable_o), 32'd1);
      tick();
      set_op(1'b0, 1'b0, EXE_LW, 32'h0, 32'h0, 5'd0, 1'b0);
      #1;
   endtask

   logic fw_on;
   logic [31:0] word_exp;

   initial begin
`ifdef MEM_STAGE_FW_EN
      fw_on = 1'b1;
`else
      fw_on = 1'b0;
`endif
      rst = 1'b0;
      bus_gnt = 1'b0;
      set_op(1'b0, 1'b0, EXE_LW, 32'h0, 32'h1234, 5'd5, 1'b1);

      // Preload while reset is held.
      preload(10'h100, 8'h78); preload(10'h101, 8'h56);
      preload(10'h102, 8'h34); preload(10'h103, 8'h12);
      preload(10'h020, 8'h80);
      preload(10'h030, 8'h01); preload(10'h031, 8'h80);
      preload(10'h040, 8'h11); preload(10'h041, 8'h00);
      preload(10'h042, 8'h00); preload(10'h043, 8'h44);
      preload(10'h080, 8'h00); preload(10'h081, 8'h00);

      // Reset: outputs forced to zero even with live inputs.
      chk("rst_rd_data", rd_data_o, 32'h0);
      chk("rst_rde", 32'(rd_enable_o), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      $display("txn reset done");

      // 1. ADD passthrough.
      tick();
      rst = 1'b1;
      set_op(1'b0, 1'b0, EXE_LW, 32'h0, 32'h1234, 5'd5, 1'b1);
      #1;
      chk("add_data", rd_data_o, 32'h1234);
      chk("add_addr", 32'(rd_addr_o), 32'd5);
      chk("add_rde", 32'(rd_enable_o), 32'd1);
      chk("add_stall", 32'(stall_req), 32'd0);
      chk("add_bus_req", 32'(bus_req), 32'd0);
      chk("add_fw", 32'(mem_fw), 32'(fw_on));
      $display("txn add passthrough data=%h", rd_data_o);

      // 2. LW at 0x100 with detailed per-cycle checks.
      tick();
      set_op(1'b1, 1'b0, EXE_LW, 32'h100, 32'h0, 5'd7, 1'b1);
      bus_gnt = 1'b1;
      #1;
      chk("lw_idle_req", 32'(bus_req), 32'd1);
      chk("lw_idle_stall", 32'(stall_req), 32'd1);
      chk("lw_idle_rde", 32'(rd_enable_o), 32'd0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("lw_mem_a", mem_a, 32'h100 + ((k > 3) ? 32'd3 : 32'(k)));
         chk("lw_stall", 32'(stall_req), 32'd1);
         chk("lw_mem_wr", 32'(mem_wr), 32'd0);
      end
      tick();
      word_exp = 32'h1234_5678;
      chk("lw_done_stall", 32'(stall_req), 32'd0);
      chk("lw_done_req", 32'(bus_req), 32'd0);
      chk("lw_done_data", rd_data_o, word_exp);
      chk("lw_done_rde", 32'(rd_enable_o), 32'd1);
      chk("lw_done_addr", 32'(rd_addr_o), 32'd7);
      chk("lw_fw_data", mem_fw_data, fw_on ? word_exp : 32'h0);
      $display("txn LW 0x100 data=%h", rd_data_o);
      tick();
      set_op(1'b0, 1'b0, EXE_LW, 32'h0, 32'h0, 5'd0, 1'b0);
      #1;

      // 3. Byte/halfword extension.
      do_load("lb", EXE_LB, 32'h20, 32'hFFFF_FF80, 1);
      $display("txn LB 0x20 data=%h", rd_data_o);
      do_load("lbu", EXE_LBU, 32'h20, 32'h0000_0080, 1);
      $display("txn LBU 0x20");
      do_load("lh", EXE_LH, 32'h30, 32'hFFFF_8001, 2);
      $display("txn LH 0x30");
      do_load("lhu", EXE_LHU, 32'h30, 32'h0000_8001, 2);
      $display("txn LHU 0x30");

      // 4. Misaligned SH.
      set_op(1'b0, 1'b1, EXE_SH, 32'h41, 32'hAABB_CCDD, 5'd3, 1'b1);
      bus_gnt = 1'b1;
      #1;
      chk("sh_idle_stall", 32'(stall_req), 32'd1);
      tick();
      chk("sh_wr0", 32'(mem_wr), 32'd1);
      chk("sh_a0", mem_a, 32'h41);
      chk("sh_d0", 32'(mem_dout), 32'hDD);
      tick();
      chk("sh_wr1", 32'(mem_wr), 32'd1);
      chk("sh_a1", mem_a, 32'h42);
      chk("sh_d1", 32'(mem_dout), 32'hCC);
      tick();
      chk("sh_done_wr", 32'(mem_wr), 32'd0);
      chk("sh_done_rde", 32'(rd_enable_o), 32'd0);
      chk("sh_done_stall", 32'(stall_req), 32'd0);
      chk("sh_ram41", 32'(ram[10'h041]), 32'hDD);
      chk("sh_ram42", 32'(ram[10'h042]), 32'hCC);
      chk("sh_ram43", 32'(ram[10'h043]), 32'h44);
      chk("sh_ram40", 32'(ram[10'h040]), 32'h11);
      $display("txn SH 0x41 data=%h", rd_data_i);
      tick();
      set_op(1'b0, 1'b0, EXE_LW, 32'h0, 32'h0, 5'd0, 1'b0);
      #1;

      // 5. Grant withheld for three cycles.
      set_op(1'b1, 1'b0, EXE_LBU, 32'h20, 32'h0, 5'd9, 1'b1);
      bus_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("nogrant_req", 32'(bus_req), 32'd1);
         chk("nogrant_stall", 32'(stall_req), 32'd1);
         chk("nogrant_mem_a", mem_a, 32'h0);
      end
      do_load("gnt_lbu", EXE_LBU, 32'h20, 32'h0000_0080, 1);
      $display("txn LBU after grant delay");

      // 6. Reset during the second ACCESS cycle of an SW.
      set_op(1'b0, 1'b1, EXE_SW, 32'h80, 32'hCAFE_BABE, 5'd4, 1'b1);
      bus_gnt = 1'b1;
      tick();
      tick();
      chk("swrst_a1", mem_a, 32'h81);
      #2;
      rst = 1'b0;
      #1;
      chk("swrst_wr", 32'(mem_wr), 32'd0);
      chk("swrst_req", 32'(bus_req), 32'd0);
      chk("swrst_stall", 32'(stall_req), 32'd0);
      chk("swrst_mem_a", mem_a, 32'h0);
      chk("swrst_data", rd_data_o, 32'h0);
      chk("swrst_rde", 32'(rd_enable_o), 32'd0);
      tick();
      chk("swrst_ram80", 32'(ram[10'h080]), 32'hBE);
      chk("swrst_ram81", 32'(ram[10'h081]), 32'h00);
      $display("txn SW aborted by reset");
      rst = 1'b1;
      do_load("post_rst_lw", EXE_LW, 32'h100, 32'h1234_5678, 4);
      $display("txn LW after reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
